// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: sequential instruction fetch with redirect, optional halt at LAST_PC and a 2-entry buffer
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   enable         allows new fetches to issue; low pauses issue, buffered data still drains
//   redirect_valid / redirect_addr   flush everything and restart fetch at redirect_addr
//   imem_addr      fetch address to a memory with a 1-cycle registered read
//   imem_data      read data for the address issued in the previous cycle
//   inst_out / pc_out / inst_valid   buffer head, popped when inst_ready is high
//   halted         fetch has stopped after issuing LAST_PC
module instr_fetch_ctrl #(
  parameter logic [5:0] RESET_PC     = 6'd0,
  parameter logic [5:0] LAST_PC      = 6'd63,
  parameter bit         STOP_AT_LAST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        redirect_valid,
  input  logic [5:0]  redirect_addr,
  output logic [5:0]  imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] inst_out,
  output logic [5:0]  pc_out,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        halted
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t      state, state_nxt;
  logic [5:0]  fetch_pc, inflight_pc;
  logic        inflight;
  logic [1:0]  fifo_count;
  logic [37:0] head_q, tail_q, entry;
  logic        pop, push, issue, head_ld, tail_ld;
  logic [2:0]  occ;
  assign imem_addr  = fetch_pc;
  assign inst_valid = fifo_count != 2'd0;
  assign {inst_out, pc_out} = head_q;
  assign halted     = state == HALT;
  assign pop        = inst_valid & inst_ready;
  assign push       = inflight & ~redirect_valid;
  assign entry      = {imem_data, inflight_pc};
  // occupancy the buffer will have once the current in-flight word lands and any pop is taken
  assign occ   = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};
  assign issue = (state == RUN) & enable & ~redirect_valid & (occ < 3'd2);
  // head takes a new word when the buffer is (or becomes) empty, or shifts up from tail on a pop
  assign head_ld = (push & ((fifo_count == 2'd0) | (pop & (fifo_count == 2'd1)))) | (pop & (fifo_count == 2'd2));
  assign tail_ld = push & (((fifo_count == 2'd1) & ~pop) | ((fifo_count == 2'd2) & pop));
  always_comb begin
    state_nxt = redirect_valid                                         ? RUN  :
                (state == IDLE && enable)                              ? RUN  :
                (issue && STOP_AT_LAST && fetch_pc == LAST_PC)         ? HALT :
                                                                         state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 6'd0;
      fifo_count  <= 2'd0;
      head_q      <= 38'd0;
      tail_q      <= 38'd0;
    end else if (redirect_valid) begin
      fetch_pc   <= redirect_addr;
      inflight   <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      inflight   <= issue;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 6'd1;
      end
      if (head_ld) head_q <= (pop && fifo_count == 2'd2) ? tail_q : entry;
      if (tail_ld) tail_q <= entry;
    end
  end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: two instances (halt at 9, and wrap-around) checked against a queue-level fetch model
module tb_instr_fetch_ctrl;
  logic        clk, rst;
  logic        en [2], rv [2], rdy [2];
  logic [5:0]  ra [2];
  logic [5:0]  a_addr, b_addr, a_pc, b_pc;
  logic [31:0] a_data, b_data, a_inst, b_inst;
  logic        a_valid, b_valid, a_halt, b_halt;
  int          n_checks = 0, n_fail = 0;
  bit          m_run [2], m_halt [2], m_fly [2];
  logic [5:0]  m_pc [2], m_fpc [2], m_q0 [2], m_q1 [2];
  int          m_cnt [2];
  instr_fetch_ctrl #(.RESET_PC(6'd0), .LAST_PC(6'd9), .STOP_AT_LAST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .enable(en[0]), .redirect_valid(rv[0]), .redirect_addr(ra[0]),
    .imem_addr(a_addr), .imem_data(a_data), .inst_out(a_inst), .pc_out(a_pc),
    .inst_valid(a_valid), .inst_ready(rdy[0]), .halted(a_halt));
  instr_fetch_ctrl #(.RESET_PC(6'd0), .LAST_PC(6'd63), .STOP_AT_LAST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .enable(en[1]), .redirect_valid(rv[1]), .redirect_addr(ra[1]),
    .imem_addr(b_addr), .imem_data(b_data), .inst_out(b_inst), .pc_out(b_pc),
    .inst_valid(b_valid), .inst_ready(rdy[1]), .halted(b_halt));
  function automatic logic [31:0] memf(input logic [5:0] a);
    return {a, 26'h0} ^ (32'(a) * 32'h0135_7ACE) ^ 32'h5A5A_1234;
  endfunction
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) begin
    a_data <= memf(a_addr);
    b_data <= memf(b_addr);
  end
  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, i, act, exp, $time);
    end
  endtask
  task automatic model_reset(input int i);
    m_run[i] = 0; m_halt[i] = 0; m_fly[i] = 0; m_pc[i] = 6'd0; m_cnt[i] = 0;
  endtask
  // advance the model by one clock edge from the inputs held during the cycle
  task automatic step(input int i);
    bit pop, iss;
    int occ;
    if (!rst) begin
      model_reset(i);
      return;
    end
    pop = m_cnt[i] > 0 && rdy[i];
    if (rv[i]) begin
      m_cnt[i] = 0; m_fly[i] = 0; m_pc[i] = ra[i]; m_run[i] = 1; m_halt[i] = 0;
      return;
    end
    occ = m_cnt[i] + int'(m_fly[i]) - int'(pop);
    iss = m_run[i] && !m_halt[i] && en[i] && occ < 2;
    if (pop) begin
      m_q0[i] = m_q1[i];
      m_cnt[i]--;
    end
    if (m_fly[i] && m_cnt[i] < 2) begin
      if (m_cnt[i] == 0) m_q0[i] = m_fpc[i];
      else m_q1[i] = m_fpc[i];
      m_cnt[i]++;
    end
    if (iss) begin
      if (i == 0 && m_pc[i] == 6'd9) m_halt[i] = 1;
      m_fpc[i] = m_pc[i];
      m_pc[i] = 6'((int'(m_pc[i]) + 1) % 64);
    end
    m_fly[i] = iss;
    if (en[i]) m_run[i] = 1;
  endtask
  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      logic [5:0] addr, pc;
      logic [31:0] inst;
      logic v, h;
      addr = i ? b_addr : a_addr; pc = i ? b_pc : a_pc; inst = i ? b_inst : a_inst;
      v = i ? b_valid : a_valid; h = i ? b_halt : a_halt;
      chk("imem_addr", i, 32'(addr), 32'(m_pc[i]));
      chk("inst_valid", i, 32'(v), 32'(m_cnt[i] != 0));
      chk("halted", i, 32'(h), 32'(m_halt[i]));
      if (m_cnt[i] != 0) begin
        chk("pc_out", i, 32'(pc), 32'(m_q0[i]));
        chk("inst_out", i, inst, memf(m_q0[i]));
      end
      if (!rst) begin
        chk("rst_pc_out", i, 32'(pc), 32'd0);
        chk("rst_inst_out", i, inst, 32'd0);
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    step(0);
    step(1);
    #1 compare();
    @(negedge clk);
  endtask
  task automatic set_all(input logic e, input logic r);
    for (int i = 0; i < 2; i++) begin
      en[i] = e; rdy[i] = r; rv[i] = 0; ra[i] = 6'd0;
    end
  endtask
  initial begin
    rst = 0;
    set_all(0, 0);
    model_reset(0);
    model_reset(1);
    #1;
    chk("reset_valid", 0, 32'(a_valid), 32'd0);
    chk("reset_addr", 1, 32'(b_addr), 32'd0);
    repeat (3) tick();
    rst = 1;
    set_all(1, 1);
    tick();
    chk("first_addr", 0, 32'(a_addr), 32'd0);
    tick();
    chk("no_valid_yet", 1, 32'(b_valid), 32'd0);
    for (int t = 3; t <= 13; t++) begin
      tick();
      if (t <= 6) chk("startup_pc", 1, 32'(b_pc), 32'(t - 3));
      if (t == 3) chk("startup_inst", 0, a_inst, memf(6'd0));
      if (t == 10) chk("not_halted_yet", 0, 32'(a_halt), 32'd0);
      if (t == 11) chk("halt_on_last", 0, 32'(a_halt), 32'd1);
      if (t == 12) chk("last_pc_out", 0, 32'(a_pc), 32'd9);
      if (t == 13) chk("drained_after_halt", 0, 32'(a_valid), 32'd0);
    end
    rv[0] = 1; ra[0] = 6'd0; rv[1] = 1; ra[1] = 6'd40;
    tick();
    rv[0] = 0; rv[1] = 0;
    chk("redir_flush", 1, 32'(b_valid), 32'd0);
    chk("redir_unhalt", 0, 32'(a_halt), 32'd0);
    tick();
    chk("redir_wait", 1, 32'(b_valid), 32'd0);
    tick();
    chk("redir_pc40", 1, 32'(b_pc), 32'd40);
    chk("redir_pc0", 0, 32'(a_pc), 32'd0);
    tick();
    chk("redir_pc41", 1, 32'(b_pc), 32'd41);
    rdy[0] = 0; rdy[1] = 0;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("stall_hold_pc", 1, 32'(b_pc), 32'd41);
      chk("stall_hold_inst", 1, b_inst, memf(6'd41));
      chk("stall_no_issue", 1, 32'(b_addr), 32'd43);
    end
    rdy[0] = 1; rdy[1] = 1;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("resume_pc", 1, 32'(b_pc), 32'(42 + t));
    end
    rv[1] = 1; ra[1] = 6'd62;
    tick();
    rv[1] = 0;
    tick();
    tick();
    chk("wrap_pc62", 1, 32'(b_pc), 32'd62);
    chk("wrap_addr0", 1, 32'(b_addr), 32'd0);
    tick();
    chk("wrap_pc63", 1, 32'(b_pc), 32'd63);
    tick();
    chk("wrap_pc0", 1, 32'(b_pc), 32'd0);
    rdy[0] = 0; rdy[1] = 0;
    repeat (3) tick();
    chk("pre_rst_valid", 1, 32'(b_valid), 32'd1);
    #2 rst = 0;
    model_reset(0);
    model_reset(1);
    #1;
    chk("async_valid", 1, 32'(b_valid), 32'd0);
    chk("async_pc", 1, 32'(b_pc), 32'd0);
    chk("async_inst", 1, b_inst, 32'd0);
    chk("async_addr", 1, 32'(b_addr), 32'd0);
    chk("async_halt", 0, 32'(a_halt), 32'd0);
    tick();
    rst = 1;
    set_all(1, 1);
    tick();
    tick();
    tick();
    chk("restart_pc", 1, 32'(b_pc), 32'd0);
    chk("restart_valid", 0, 32'(a_valid), 32'd1);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        en[i]  = $urandom_range(9) < 8;
        rdy[i] = $urandom_range(9) < 7;
        rv[i]  = $urandom_range(99) < 4;
        ra[i]  = ($urandom_range(3) == 0) ? 6'($urandom_range(63, 58)) : 6'($urandom);
      end
      if ($urandom_range(499) == 0) begin
        rst = 0;
        model_reset(0);
        model_reset(1);
      end else rst = 1;
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
